prefetch_buffer: RTL and testbench
==================================

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered imem requests; 1..DEPTH.
REQ-003 clk_i  input  1  core clock; all state changes on rising edge.
REQ-004 rst_n_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 boot_addr_i  input  30  word address of first fetch; stable while rst_n_i low.
REQ-006 redirect_i  input  1  flush buffer and restart fetch (branch, jump, trap, mret).
REQ-007 redirect_addr_i  input  32  restart address; bits [1:0] ignored.
REQ-008 imem_req_o  output  1  fetch request.
REQ-009 imem_addr_o  output  32  word-aligned fetch address.
REQ-010 imem_gnt_i  input  1  request accepted this cycle; meaningful only when imem_req_o=1.
REQ-011 imem_rvalid_i  input  1  response valid; responses in request order, >= 1 cycle after grant.
REQ-012 imem_rdata_i  input  32  response instruction word.
REQ-013 imem_err_i  input  1  response bus error; qualified by imem_rvalid_i.
REQ-014 instr_valid_o  output  1  head entry valid toward IF/ID.
REQ-015 instr_rdata_o  output  32  head instruction word.
REQ-016 instr_addr_o  output  32  head instruction address (PC).
REQ-017 instr_err_o  output  1  head entry carries fetch error.
REQ-018 instr_ready_i  input  1  consumer accepts head; pop when instr_valid_o & instr_ready_i.
REQ-019 busy_o  output  1  requests in flight or FIFO non-empty.

Function
REQ-020 State: fetch_addr (next request), resp_addr (address of next accepted response), FIFO of {rdata, addr, err}, in_flight count, discard count.
REQ-021 imem_req_o = !redirect_i & (count + in_flight < DEPTH) & (in_flight < MAX_OUTSTANDING), where in_flight includes discards.
REQ-022 imem_addr_o = fetch_addr; once imem_req_o is high, address held stable until grant or redirect.
REQ-023 Grant (imem_req_o & imem_gnt_i): fetch_addr += 4 (mod 2^32, 0xFFFFFFFC wraps to 0), in_flight += 1.
REQ-024 Response with discard > 0: dropped, discard -= 1, in_flight -= 1.
REQ-025 Response with discard = 0: push {imem_rdata_i, resp_addr, imem_err_i}, resp_addr += 4, in_flight -= 1.
REQ-026 Grant and response in same cycle: in_flight unchanged.
REQ-027 REQ-021 makes push-when-full impossible; an overflow is a design error, flagged by a bench assertion.
REQ-028 Push and pop in same cycle: count unchanged; any occupancy, including full.
REQ-029 Pop with FIFO empty: no effect; instr_valid_o = 0.
REQ-030 instr_valid_o = (count != 0) & !redirect_i; data outputs show head entry, don't-care when invalid.
REQ-031 Minimum latency: grant in cycle N, rvalid in N+1, instr_valid_o in N+2; no bypass path.
REQ-032 Sustained throughput of 1 instruction/cycle when memory grants every cycle with 1-cycle response and MAX_OUTSTANDING >= 2.
REQ-033 Redirect cycle: FIFO emptied, fetch_addr = resp_addr = {redirect_addr_i[31:2],2'b00}, discard = in_flight minus (1 if imem_rvalid_i this cycle), pop ignored.
REQ-034 Redirect while discard > 0: REQ-033 formula still applies; all in-flight responses dropped.
REQ-035 Back-to-back redirects: last redirect address wins; nothing from earlier streams reaches FIFO.
REQ-036 Error responses are stored, not retried; fetching continues sequentially until redirect.
REQ-037 busy_o = (in_flight != 0) | (count != 0).

Reset
REQ-038 While rst_n_i low: fetch_addr = resp_addr = {boot_addr_i,2'b00}, count = in_flight = discard = 0, instr_valid_o = 0, busy_o = 0, imem_req_o = 0.
REQ-039 Reset mid-operation discards all state; the bench does not return responses for pre-reset requests.
REQ-040 First imem_req_o is in the first cycle after rst_n_i deasserts.

Verification
REQ-041 boot_addr_i=0x0000_0020, memory grants every cycle with 1-cycle latency, ready=1 -> addresses 0x80,0x84,0x88... appear on instr_addr_o in order, 1 per cycle after a 2-cycle fill.
REQ-042 instr_ready_i=0 for 10 cycles -> exactly DEPTH (4) entries buffered, imem_req_o low, no loss; ready=1 -> in-order drain with fetch resumed.
REQ-043 Two requests in flight (0x100, 0x104), redirect to 0x203 -> both responses dropped, next instr_addr_o = 0x200.
REQ-044 Redirect in the cycle a response arrives, then again 1 cycle later -> only the second target's stream reaches output.
REQ-045 Response with imem_err_i=1 at 0x40 -> instr_err_o=1 only for entry 0x40; 0x44 follows with error clear.
REQ-046 Fetch from 0xFFFFFFF8 -> 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; async reset asserted mid-stream -> outputs cleared immediately.

Source files
------------

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches to imem, keeps
// responses in an in-order FIFO toward IF/ID and drops stale responses after
// a redirect by counting how many in-flight replies belong to the old stream.
module prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [29:0] boot_addr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];
    logic [31:0]        fetch_addr_q, fetch_addr_d;
    logic [31:0]        resp_addr_q, resp_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   in_flight_q, in_flight_d;
    logic [CNT_W-1:0]   discard_q, discard_d;

    logic [CNT_W:0]     occ;
    logic [31:0]        redir_tgt;
    logic               grant, push, pop, drop;
    logic               unused_addr_lsbs;

    // Low address bits of the redirect target carry no information.
    assign unused_addr_lsbs = &{1'b0, redirect_addr_i[1:0]};
    assign redir_tgt        = {redirect_addr_i[31:2], 2'b00};

    // Requests are throttled so every in-flight reply (kept or discarded)
    // is guaranteed a slot; this is what makes FIFO overflow impossible.
    assign occ        = {1'b0, count_q} + {1'b0, in_flight_q};
    assign imem_req_o = rst_n_i & ~redirect_i
                      & (occ < (CNT_W+1)'(DEPTH))
                      & (in_flight_q < CNT_W'(MAX_OUTSTANDING));
    assign imem_addr_o = fetch_addr_q;

    assign grant = imem_req_o & imem_gnt_i;
    assign drop  = imem_rvalid_i & (discard_q != '0);
    assign push  = imem_rvalid_i & (discard_q == '0) & ~redirect_i;
    assign pop   = instr_valid_o & instr_ready_i;

    assign instr_valid_o = (count_q != '0) & ~redirect_i;
    assign instr_rdata_o = fifo_q[rd_ptr_q].rdata;
    assign instr_addr_o  = fifo_q[rd_ptr_q].addr;
    assign instr_err_o   = fifo_q[rd_ptr_q].err;
    assign busy_o        = (in_flight_q != '0) | (count_q != '0);

    // Next-state: redirect flushes everything and converts all in-flight
    // replies (except one arriving right now) into discards.
    always_comb begin
        fifo_d       = fifo_q;
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        discard_d    = discard_q;
        in_flight_d  = in_flight_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
        if (redirect_i) begin
            fetch_addr_d = redir_tgt;
            resp_addr_d  = redir_tgt;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            discard_d    = in_flight_q - CNT_W'(imem_rvalid_i);
        end else begin
            if (grant)
                fetch_addr_d = fetch_addr_q + 32'd4;
            if (drop)
                discard_d = discard_q - CNT_W'(1);
            if (push) begin
                fifo_d[wr_ptr_q] = '{rdata: imem_rdata_i, addr: resp_addr_q, err: imem_err_i};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                resp_addr_d      = resp_addr_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset reloads the boot address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            fetch_addr_q <= {boot_addr_i, 2'b00};
            resp_addr_q  <= {boot_addr_i, 2'b00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_flight_q  <= '0;
            discard_q    <= '0;
        end else begin
            fifo_q       <= fifo_d;
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_flight_q  <= in_flight_d;
            discard_q    <= discard_d;
        end
    end
endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: randomized imem timing and consumer stalls,
// checked against a stream model (granted-address queue tagged by redirect
// epoch, buffered-instruction queue, expected PC sequence).
module tb_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [29:0] boot_addr_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_err_o;
    logic        instr_ready_i = 1'b0;
    logic        busy_o;

    prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .boot_addr_i(boot_addr_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o), .instr_err_o(instr_err_o),
        .instr_ready_i(instr_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } ent_t;

    pend_t       pq[$];
    ent_t        mq[$];
    int          epoch = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          pops = 0;
    logic [31:0] exp_fetch, exp_pc;

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[7:2] == 6'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One cycle, entered and left at a falling edge: drive, check outputs
    // against the model, then advance the model through the rising edge.
    task automatic step(input logic redir, input logic [31:0] raddr, input logic rdy,
                        input int gp, input int rp);
        pend_t e;
        ent_t  m;
        int    n_if;
        logic  rv, g, ev, er;
        n_if            = pq.size();
        redirect_i      = redir;
        redirect_addr_i = raddr;
        instr_ready_i   = rdy;
        rv = 1'b0;
        if (n_if > 0 && pq[0].due <= cyc && int'($urandom % 100) < rp) begin
            rv = 1'b1;
            e  = pq.pop_front();
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? hsh(e.addr) : $urandom;
        imem_err_i    = rv ? is_err(e.addr) : 1'($urandom);
        g             = int'($urandom % 100) < gp;
        imem_gnt_i    = g;
        #1;
        er = !redir && (mq.size() + n_if < DEPTH) && (n_if < MAXO);
        ev = (mq.size() != 0) && !redir;
        chk("imem_req", imem_req_o, er);
        chk("instr_valid", instr_valid_o, ev);
        chk("busy", busy_o, (n_if != 0) || (mq.size() != 0));
        if (er) chk("imem_addr", imem_addr_o, exp_fetch);
        if (ev) begin
            chk("instr_addr", instr_addr_o, mq[0].addr);
            chk("instr_rdata", instr_rdata_o, mq[0].rdata);
            chk("instr_err", instr_err_o, mq[0].err);
        end
        if (redir) begin
            epoch++;
            mq.delete();
            exp_fetch = {raddr[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end else if (ev && rdy) begin
            chk("pc_order", instr_addr_o, exp_pc);
            exp_pc = exp_pc + 32'd4;
            void'(mq.pop_front());
            pops++;
        end
        if (rv && e.epoch == epoch) begin
            m.addr  = e.addr;
            m.rdata = hsh(e.addr);
            m.err   = is_err(e.addr);
            mq.push_back(m);
        end
        chk("fifo_bound", 32'(mq.size() <= DEPTH), 32'd1);
        if (er && g) begin
            pq.push_back('{exp_fetch, epoch, cyc + 1});
            exp_fetch = exp_fetch + 32'd4;
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input logic [29:0] boot);
        boot_addr_i   = boot;
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req", imem_req_o, 1'b0);
        pq.delete();
        mq.delete();
        epoch++;
        exp_fetch = {boot, 2'b00};
        exp_pc    = exp_fetch;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0;
        logic found;
        @(negedge clk_i);
        do_reset(30'h20);

        // Full-speed streaming from boot: 1 instruction per cycle after fill.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 100, 100);
        p0 = pops;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 100, 100);
        chk("throughput", pops - p0, 20);

        // Consumer stall: buffer fills to DEPTH, requests stop, then drains.
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 100, 100);
        chk("stall_req", imem_req_o, 1'b0);
        chk("stall_valid", instr_valid_o, 1'b1);
        chk("stall_fill", mq.size(), DEPTH);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 100, 100);

        // Two requests outstanding, then redirect to an unaligned target.
        step(1'b1, 32'h100, 1'b1, 100, 100);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 100, 0);
        step(1'b1, 32'h203, 1'b0, 100, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b0, 100, 100);
            found = instr_valid_o;
        end
        chk("redir_seen", found, 1'b1);
        chk("redir_first", instr_addr_o, 32'h200);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 100, 100);

        // Redirect on a response cycle, then again the next cycle.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 100, 100);
        step(1'b1, 32'h500, 1'b1, 100, 100);
        step(1'b1, 32'h600, 1'b1, 100, 100);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 100, 100);

        // Error response at 0x40 only.
        step(1'b1, 32'h3C, 1'b1, 100, 100);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 100, 100);

        // Address wrap, then asynchronous reset in the middle of the stream.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 100, 100);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 100, 100);
        do_reset(30'h10);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 100, 100);

        // Random traffic: variable grant/response timing, stalls, redirects.
        for (int i = 0; i < 2000; i++)
            step(int'($urandom % 100) < 4, $urandom, int'($urandom % 100) < 70,
                 int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));

        // Quiesce: no new grants, let everything drain.
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 0, 100);
        chk("idle_busy", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
